dual_port_ram: RTL and testbench

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

---
 rtl/dual_port_ram.sv | 80 ++++++++
 tb/tb_dual_port_ram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// Dual-port RAM on a single clock: port A sees DWA-bit words, port B sees MULTNUM
// adjacent port-A words packed into one DWB-bit word. Registered, read-first outputs.
module dual_port_ram #(
    parameter int AWA     = 5,
    parameter int DWA     = 16,
    parameter int AWB     = 5,
    parameter int DWB     = 16,
    parameter int MULTNUM = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DWA-1:0] i_data_a,
    input  logic [AWA-1:0] i_addr_a,
    input  logic           i_wr_en_a,
    output logic [DWA-1:0] o_data_a,
    input  logic [DWB-1:0] i_data_b,
    input  logic [AWB-1:0] i_addr_b,
    input  logic           i_wr_en_b,
    output logic [DWB-1:0] o_data_b
);

    localparam int LGM   = $clog2(MULTNUM);
    localparam int DEPTH = 1 << AWA;

    if (!(MULTNUM == 1 || MULTNUM == 2 || MULTNUM == 4)) begin : g_bad_multnum
        $error("dual_port_ram: MULTNUM must be 1, 2 or 4");
    end
    if (DWB != DWA * MULTNUM) begin : g_bad_dwb
        $error("dual_port_ram: DWB must equal DWA*MULTNUM");
    end
    if (AWB != AWA - LGM) begin : g_bad_awb
        $error("dual_port_ram: AWB must equal AWA-log2(MULTNUM)");
    end

    logic [DWA-1:0] mem [DEPTH];
    logic [DWA-1:0] data_a_q, data_a_d;
    logic [DWB-1:0] data_b_q, data_b_d;

    // Port-A word holding sub-word k of port-B word addr.
    function automatic logic [AWA-1:0] b_word(input logic [AWB-1:0] addr, input int k);
        return (AWA'(addr) << LGM) | AWA'(k);
    endfunction

    // Port A is written after port B so it wins any overlapping word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (i_wr_en_b) begin
                for (int k = 0; k < MULTNUM; k++) begin
                    mem[b_word(i_addr_b, k)] <= i_data_b[k*DWA +: DWA];
                end
            end
            if (i_wr_en_a) begin
                mem[i_addr_a] <= i_data_a;
            end
        end
    end

    always_comb begin
        data_a_d = mem[i_addr_a];
        data_b_d = '0;
        for (int k = 0; k < MULTNUM; k++) begin
            data_b_d[k*DWA +: DWA] = mem[b_word(i_addr_b, k)];
        end
    end

    // Reads sample the array before this edge's writes land, giving read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign o_data_a = data_a_q;
    assign o_data_b = data_b_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: vector table with a latency-1 scoreboard on the default
// configuration, plus hand sequences for the MULTNUM=2 mapping and async reset.
module tb_dual_port_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] data_a = '0, data_b = '0, q_a, q_b;
    logic [4:0]  addr_a = '0, addr_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0;

    logic [7:0]  m2_data_a = '0, m2_q_a;
    logic [15:0] m2_data_b = '0, m2_q_b;
    logic [4:0]  m2_addr_a = '0;
    logic [3:0]  m2_addr_b = '0;
    logic        m2_we_a = 1'b0, m2_we_b = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_port_ram u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_data_a(data_a), .i_addr_a(addr_a), .i_wr_en_a(we_a), .o_data_a(q_a),
        .i_data_b(data_b), .i_addr_b(addr_b), .i_wr_en_b(we_b), .o_data_b(q_b)
    );

    dual_port_ram #(.AWA(5), .DWA(8), .AWB(4), .DWB(16), .MULTNUM(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_data_a(m2_data_a), .i_addr_a(m2_addr_a), .i_wr_en_a(m2_we_a), .o_data_a(m2_q_a),
        .i_data_b(m2_data_b), .i_addr_b(m2_addr_b), .i_wr_en_b(m2_we_b), .o_data_b(m2_q_b)
    );

    typedef struct {
        bit          wa;
        logic [4:0]  aa;
        logic [15:0] da;
        bit          wb;
        logic [4:0]  ab;
        logic [15:0] db;
        bit          ca;
        logic [15:0] ea;
        bit          cb;
        logic [15:0] eb;
    } vec_t;

    typedef struct {
        int          idx;
        bit          ca;
        logic [15:0] ea;
        bit          cb;
        logic [15:0] eb;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    function automatic vec_t v(bit wa, int aa, int da, bit wb, int ab, int db,
                               bit ca, int ea, bit cb, int eb);
        vec_t r;
        r.wa = wa; r.aa = 5'(aa); r.da = 16'(da);
        r.wb = wb; r.ab = 5'(ab); r.db = 16'(db);
        r.ca = ca; r.ea = 16'(ea);
        r.cb = cb; r.eb = 16'(eb);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        // Read-first and cross-port-old behaviour means unwritten locations are never checked.
        vecs[0]  = v(1, 3,  'h1234, 0, 3,  0,      0, 0,      0, 0);
        vecs[1]  = v(0, 3,  0,      0, 3,  0,      1, 'h1234, 1, 'h1234);
        vecs[2]  = v(1, 7,  'h0707, 0, 3,  0,      0, 0,      1, 'h1234);
        vecs[3]  = v(0, 7,  0,      1, 7,  'hBEEF, 1, 'h0707, 1, 'h0707);
        vecs[4]  = v(0, 7,  0,      0, 7,  0,      1, 'hBEEF, 1, 'hBEEF);
        vecs[5]  = v(1, 5,  'h5555, 0, 3,  0,      0, 0,      1, 'h1234);
        vecs[6]  = v(1, 5,  'hAAAA, 0, 5,  0,      1, 'h5555, 1, 'h5555);
        vecs[7]  = v(0, 5,  0,      0, 5,  0,      1, 'hAAAA, 1, 'hAAAA);
        vecs[8]  = v(1, 9,  'h1111, 1, 9,  'h2222, 0, 0,      0, 0);
        vecs[9]  = v(0, 9,  0,      0, 9,  0,      1, 'h1111, 1, 'h1111);
        vecs[10] = v(0, 3,  0,      1, 31, 'hCAFE, 1, 'h1234, 0, 0);
        vecs[11] = v(0, 31, 0,      0, 31, 0,      1, 'hCAFE, 1, 'hCAFE);
        vecs[12] = v(1, 0,  'h0001, 0, 9,  0,      0, 0,      1, 'h1111);
        vecs[13] = v(0, 0,  0,      0, 0,  0,      1, 'h0001, 1, 'h0001);

        #1;
        check("reset_q_a", q_a, 16'h0000);
        check("reset_q_b", q_b, 16'h0000);
        check("reset_m2_q_a", {8'h00, m2_q_a}, 16'h0000);
        check("reset_m2_q_b", m2_q_b, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            we_a = vecs[i].wa; addr_a = vecs[i].aa; data_a = vecs[i].da;
            we_b = vecs[i].wb; addr_b = vecs[i].ab; data_b = vecs[i].db;
            e.idx = i; e.ca = vecs[i].ca; e.ea = vecs[i].ea;
            e.cb = vecs[i].cb; e.eb = vecs[i].eb;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            if (got.ca) check($sformatf("vec%0d_q_a", got.idx), q_a, got.ea);
            if (got.cb) check($sformatf("vec%0d_q_b", got.idx), q_b, got.eb);
        end
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;

        // Wide port B over 8-bit port A: word k of B address N is A address 2N+k.
        m2_we_a = 1'b1; m2_addr_a = 5'd0; m2_data_a = 8'h34;
        @(negedge clk);
        m2_addr_a = 5'd1; m2_data_a = 8'h12;
        @(negedge clk);
        m2_we_a = 1'b0; m2_addr_b = 4'd0;
        @(posedge clk); #1;
        check("m2_b_read0", m2_q_b, 16'h1234);
        check("m2_a_read1", {8'h00, m2_q_a}, 16'h0012);
        @(negedge clk);
        m2_we_b = 1'b1; m2_addr_b = 4'd2; m2_data_b = 16'hABCD;
        @(negedge clk);
        m2_we_b = 1'b0; m2_addr_a = 5'd4;
        @(posedge clk); #1;
        check("m2_a_read4", {8'h00, m2_q_a}, 16'h00CD);
        check("m2_b_read2", m2_q_b, 16'hABCD);
        @(negedge clk);
        m2_addr_a = 5'd5;
        @(posedge clk); #1;
        check("m2_a_read5", {8'h00, m2_q_a}, 16'h00AB);
        @(negedge clk);
        m2_we_a = 1'b1; m2_addr_a = 5'd6; m2_data_a = 8'h11;
        m2_we_b = 1'b1; m2_addr_b = 4'd3; m2_data_b = 16'h2233;
        @(negedge clk);
        m2_we_a = 1'b0; m2_we_b = 1'b0; m2_addr_a = 5'd7;
        @(posedge clk); #1;
        check("m2_overlap_b3", m2_q_b, 16'h2211);
        check("m2_overlap_a7", {8'h00, m2_q_a}, 16'h0022);

        // Asynchronous reset in the middle of traffic.
        @(negedge clk);
        addr_a = 5'd7; addr_b = 5'd31;
        @(posedge clk); #1;
        check("pre_rst_q_a", q_a, 16'hBEEF);
        check("pre_rst_q_b", q_b, 16'hCAFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q_a", q_a, 16'h0000);
        check("async_rst_q_b", q_b, 16'h0000);
        check("async_rst_m2_q_b", m2_q_b, 16'h0000);
        we_a = 1'b1; data_a = 16'hDEAD;
        we_b = 1'b1; data_b = 16'h0BAD;
        m2_we_b = 1'b1; m2_data_b = 16'hFFFF;
        @(posedge clk); #1;
        check("in_rst_q_a", q_a, 16'h0000);
        check("in_rst_q_b", q_b, 16'h0000);
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0; m2_we_b = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rel_q_a", q_a, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("after_rst_q_a", q_a, 16'hBEEF);
        check("after_rst_q_b", q_b, 16'hCAFE);
        check("after_rst_m2_q_b", m2_q_b, 16'h2211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
